sm_dbg_arbiter: RTL and testbench
=================================

// Module: sm_dbg_arbiter
// PURPOSE
//  Round-robin arbiter sharing the core's two debug read ports (register-file
//  read port regAddr/regData, data-memory port B memAddrB/memDataOutB) among
//  NREQ board-side requesters (LED driver, 7-segment scanner, UART dumper).
//  Sits in the board top between sm_top's debug ports and the display logic.
//  One read transaction in flight at a time; result returned with a one-cycle ack.
// PARAMETERS
//  NREQ    3   number of requesters (2..8)
//  GNT_W   2   width of grantId, >= clog2(NREQ)
//  ADDR_W  6   request address width; also width of memAddrB
//  REG_AW  5   register address width; regAddr = address[REG_AW-1:0]
//  DATA_W  32  read data width
// PORTS
//  clk          in   1             system clock (sm_top clk output)
//  rst          in   1             asynchronous reset, active-high
//  req          in   NREQ          per-requester read request, held until ack
//  reqMem       in   NREQ          per-requester target: 1 = memory port B, 0 = register
//  reqAddr      in   NREQ*ADDR_W   requester i address at [i*ADDR_W +: ADDR_W]
//  ack          out  NREQ          one-cycle pulse to granted requester; rdata valid
//  rdata        out  DATA_W        captured read data, held until next capture
//  busy         out  1             high in every state except IDLE
//  grantId      out  GNT_W         index of current/last granted requester
//  regAddr      out  REG_AW        to sm_top regAddr
//  regData      in   DATA_W        from sm_top regData (combinational read)
//  memAddrB     out  ADDR_W        to sm_top memAddrB
//  memDataOutB  in   DATA_W        from sm_top memDataOutB (1-cycle registered read)
// BEHAVIOUR
//  Reset: state=IDLE; ack=0, busy=0, rdata=0, grantId=0, regAddr=0, memAddrB=0,
//   rr pointer last=NREQ-1 (requester 0 has top priority after reset).
//  Asserting rst in any state aborts the transaction: no ack is issued.
//  FSM states: IDLE, ISSUE, WAIT, ACK.
//  IDLE: if any req bit set at edge E: pick first set bit searching last+1,
//   last+2, ... (mod NREQ); register grantId, target, address; last<=grant;
//   ->ISSUE. req/reqMem/reqAddr sampled only in IDLE.
//  ISSUE: regAddr (register target) or memAddrB (memory target) driven from
//   the registered address. Register: rdata<=regData, ->ACK. Memory: ->WAIT.
//  WAIT: rdata<=memDataOutB, ->ACK.
//  ACK: ack[grantId]=1 for exactly this cycle, all other ack bits 0; ->IDLE.
//  Latency from sampling edge E: register ack high in cycle after E+1; memory
//   ack high in cycle after E+2. Min spacing of grants: 3 cycles (reg), 4 (mem).
//  The unused address port holds its previous value; both hold between grants.
//  Requester dropping req after grant: transaction completes, ack still pulses.
//  Requester holding req after ack: treated as new request in next IDLE.
//  Pointer wrap: after grant to NREQ-1 search restarts at 0.
//  Single requester continuously requesting gets back-to-back grants.
//  Address bits above REG_AW ignored for register reads.
// TESTING
//  1 Reset: rst pulse mid-ISSUE -> all outputs 0, no ack, next grant to req 0.
//  2 Reg read: req=001, reqMem=000, addr0=2, regData=0x0000_00A5 -> ack=001
//    2 cycles after sampling edge, rdata=0x0000_00A5, regAddr=2.
//  3 Mem read: req=010, reqMem=010, addr1=0x3F, memory model 1-cycle latency
//    returns 0xDEAD_BEEF -> memAddrB=0x3F, ack=010 3 cycles after edge, rdata=0xDEADBEEF.
//  4 Fairness: req=111 held continuously, all reg reads -> grant order
//    0,1,2,0,1,2; each ack single-cycle, one-hot, never overlapping.
//  5 Drop: req1 deasserted the cycle after grant -> ack[1] still pulses once;
//    no second grant to 1 while req1=0.
//  6 Random: mixed reg/mem traffic 10k cycles vs. reference model -> rdata
//    matches, no requester starved > NREQ grants.

Source files
------------

// File: rtl/sm_dbg_arbiter.sv
// sm_dbg_arbiter: round-robin arbiter that shares the core's register-file
// debug read port and data-memory port B among NREQ board-side requesters.
// One read is in flight at a time, and each read finishes with a one-cycle ack.
//
// Handshake: a requester raises req[i] together with reqMem[i] and its address,
// and holds them until it sees ack[i]. ack[i] is a single-cycle pulse. rdata is
// valid in that cycle and stays put until the next capture. req/reqMem/reqAddr
// are only looked at while the arbiter is idle.
module sm_dbg_arbiter #(
   parameter int NREQ   = 3,
   parameter int GNT_W  = 2,
   parameter int ADDR_W = 6,
   parameter int REG_AW = 5,
   parameter int DATA_W = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NREQ-1:0]        req,
   input  logic [NREQ-1:0]        reqMem,
   input  logic [NREQ*ADDR_W-1:0] reqAddr,
   output logic [NREQ-1:0]        ack,
   output logic [DATA_W-1:0]      rdata,
   output logic                   busy,
   output logic [GNT_W-1:0]       grantId,
   output logic [REG_AW-1:0]      regAddr,
   input  logic [DATA_W-1:0]      regData,
   output logic [ADDR_W-1:0]      memAddrB,
   input  logic [DATA_W-1:0]      memDataOutB,
   output logic [1:0]             dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_ACK   = 2'd3
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [GNT_W-1:0]    last;       // most recently granted requester
   logic                tgt_mem;    // target of the transaction in flight
   logic                pick_valid;
   logic [GNT_W-1:0]    pick_idx;
   logic [GNT_W-1:0]    cand;
   logic [ADDR_W-1:0]   addr_sel;

   // Round-robin search: the first requesting index after 'last', with wrap.
   always_comb begin
      pick_valid = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = GNT_W'((int'(last) + k) % NREQ);
         if (!pick_valid && req[cand]) begin
            pick_valid = 1'b1;
            pick_idx   = cand;
         end
      end
      addr_sel = reqAddr[pick_idx*ADDR_W +: ADDR_W];
   end

   // State register; reset aborts any transaction in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic. Memory reads take one extra cycle because port B is registered.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (pick_valid) state_nxt = S_ISSUE;
         S_ISSUE: state_nxt = tgt_mem ? S_WAIT : S_ACK;
         S_WAIT:  state_nxt = S_ACK;
         S_ACK:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Datapath: latch the grant and address in IDLE, then capture the read data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last     <= GNT_W'(NREQ - 1);
         grantId  <= '0;
         tgt_mem  <= 1'b0;
         regAddr  <= '0;
         memAddrB <= '0;
         rdata    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (pick_valid) begin
                  grantId <= pick_idx;
                  last    <= pick_idx;
                  tgt_mem <= reqMem[pick_idx];
                  // Only the port being used moves; the other keeps its old address.
                  if (reqMem[pick_idx]) memAddrB <= addr_sel;
                  else                  regAddr  <= addr_sel[REG_AW-1:0];
               end
            end
            S_ISSUE: if (!tgt_mem) rdata <= regData;
            S_WAIT:  rdata <= memDataOutB;
            default: ;
         endcase
      end
   end

   // Status outputs: busy in any state other than idle, and ack only for the granted requester.
   always_comb begin
      ack       = '0;
      busy      = (state != S_IDLE);
      dbg_state = state;
      if (state == S_ACK) ack = NREQ'(1) << grantId;
   end

endmodule

// File: tb/tb_sm_dbg_arbiter.sv
// tb_sm_dbg_arbiter: directed and randomised checks of sm_dbg_arbiter against
// a bench-side register file, a memory with a one-cycle read latency and a
// round-robin reference model.
module tb_sm_dbg_arbiter;

   localparam int NREQ   = 3;
   localparam int GNT_W  = 2;
   localparam int ADDR_W = 6;
   localparam int REG_AW = 5;
   localparam int DATA_W = 32;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [NREQ-1:0]        req;
   logic [NREQ-1:0]        reqMem;
   logic [NREQ*ADDR_W-1:0] reqAddr;
   logic [NREQ-1:0]        ack;
   logic [DATA_W-1:0]      rdata;
   logic                   busy;
   logic [GNT_W-1:0]       grantId;
   logic [REG_AW-1:0]      regAddr;
   logic [DATA_W-1:0]      regData;
   logic [ADDR_W-1:0]      memAddrB;
   logic [DATA_W-1:0]      memDataOutB;
   logic [1:0]             dbg_state;

   // Bench-side storage: a combinational register file and a memory read
   // that is registered for one cycle.
   logic [DATA_W-1:0] regs [32];
   logic [DATA_W-1:0] mem  [64];
   assign regData = regs[regAddr];
   always @(posedge clk) memDataOutB <= mem[memAddrB];

   sm_dbg_arbiter #(
      .NREQ(NREQ), .GNT_W(GNT_W), .ADDR_W(ADDR_W), .REG_AW(REG_AW), .DATA_W(DATA_W)
   ) dut (
      .clk(clk), .rst(rst), .req(req), .reqMem(reqMem), .reqAddr(reqAddr),
      .ack(ack), .rdata(rdata), .busy(busy), .grantId(grantId),
      .regAddr(regAddr), .regData(regData), .memAddrB(memAddrB),
      .memDataOutB(memDataOutB), .dbg_state(dbg_state)
   );

   // ---------------- scoreboard ----------------
   int total = 0;
   int bad   = 0;
   logic [DATA_W-1:0] exp_q[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_addr(input int i, input logic [ADDR_W-1:0] a);
      reqAddr[i*ADDR_W +: ADDR_W] = a;
   endtask

   // Steps until a nonzero ack appears or the bound expires. lat counts
   // clock edges from the sampling edge onwards.
   task automatic wait_ack(output logic [NREQ-1:0] a, output int lat);
      a   = '0;
      lat = 0;
      while (a == '0 && lat < 20) begin
         step();
         lat++;
         a = ack;
      end
   endtask

   // Issues one request and waits for its ack. It then releases req and
   // steps once, so that the arbiter is back in idle.
   task automatic do_txn(input logic [NREQ-1:0] r, input logic [NREQ-1:0] m,
                         output logic [NREQ-1:0] a, output int lat);
      req    = r;
      reqMem = m;
      wait_ack(a, lat);
      req = '0;
      step();
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
   endtask

   logic [NREQ-1:0]   a;
   int                lat;
   logic [NREQ-1:0]   prev_ack;
   int                n;
   int                cnt_own;
   int                cnt_other;

   // random-phase model state
   int                model_last;
   int                cur_gnt;
   int                pred;
   logic [REG_AW-1:0] model_reg;
   logic [ADDR_W-1:0] model_mem;
   logic [ADDR_W-1:0] ga;
   logic              prev_busy;
   int                wait_cnt [NREQ];

   initial begin
      rst     = 1'b1;
      req     = '0;
      reqMem  = '0;
      reqAddr = '0;
      for (int i = 0; i < 32; i++) regs[i] = $urandom;
      for (int i = 0; i < 64; i++) mem[i]  = $urandom;
      regs[2]     = 32'h0000_00A5;
      mem[6'h3F]  = 32'hDEAD_BEEF;

      // ---- reset state ----
      step();
      step();
      check("rst_ack", ack, 0);
      check("rst_busy", busy, 0);
      check("rst_rdata", rdata, 0);
      check("rst_gnt", grantId, 0);
      check("rst_regaddr", regAddr, 0);
      check("rst_memaddr", memAddrB, 0);
      check("rst_state", dbg_state, 0);
      rst = 1'b0;
      step();

      // ---- test 1: reset in the middle of ISSUE ----
      set_addr(2, 6'h15);
      do_txn(3'b100, 3'b100, a, lat);
      check("t1_pre_mem_ack", a, 3'b100);
      check("t1_pre_mem_rdata", rdata, mem[6'h15]);
      set_addr(1, 6'h07);
      do_txn(3'b010, 3'b000, a, lat);
      check("t1_pre_reg_ack", a, 3'b010);
      check("t1_pre_reg_rdata", rdata, regs[7]);
      set_addr(0, 6'h02);
      req    = 3'b111;
      reqMem = 3'b000;
      step();
      check("t1_issue_busy", busy, 1);
      check("t1_issue_gnt", grantId, 2);
      check("t1_issue_state", dbg_state, 1);
      #1 rst = 1'b1;
      #1;
      check("t1_async_ack", ack, 0);
      check("t1_async_busy", busy, 0);
      check("t1_async_rdata", rdata, 0);
      check("t1_async_gnt", grantId, 0);
      check("t1_async_regaddr", regAddr, 0);
      check("t1_async_memaddr", memAddrB, 0);
      step();
      check("t1_rst_noack0", ack, 0);
      step();
      check("t1_rst_noack1", ack, 0);
      rst = 1'b0;
      wait_ack(a, lat);
      check("t1_after_ack", a, 3'b001);
      check("t1_after_lat", lat, 2);
      req = '0;
      step();

      // ---- test 2: register read ----
      set_addr(0, 6'h02);
      do_txn(3'b001, 3'b000, a, lat);
      check("t2_ack", a, 3'b001);
      check("t2_lat", lat, 2);
      check("t2_rdata", rdata, 32'h0000_00A5);
      check("t2_regaddr", regAddr, 2);
      check("t2_memaddr_hold", memAddrB, 0);

      // ---- test 3: memory read ----
      set_addr(1, 6'h3F);
      do_txn(3'b010, 3'b010, a, lat);
      check("t3_ack", a, 3'b010);
      check("t3_lat", lat, 3);
      check("t3_rdata", rdata, 32'hDEAD_BEEF);
      check("t3_memaddr", memAddrB, 6'h3F);
      check("t3_regaddr_hold", regAddr, 2);

      // ---- test 4: fairness with all three requesting ----
      pulse_reset();
      set_addr(0, 6'h03);
      set_addr(1, 6'h04);
      set_addr(2, 6'h05);
      reqMem   = 3'b000;
      req      = 3'b111;
      n        = 0;
      prev_ack = '0;
      for (int s = 0; s < 60 && n < 6; s++) begin
         step();
         if (ack != '0) begin
            check("t4_gap", prev_ack, 0);
            check("t4_ack", ack, NREQ'(1) << (n % NREQ));
            check("t4_rdata", rdata, regs[3 + (n % NREQ)]);
            n++;
         end
         prev_ack = ack;
      end
      check("t4_count", n, 6);
      req = '0;
      step();

      // ---- test 5: requester drops req after being granted ----
      set_addr(1, 6'h09);
      reqMem = 3'b000;
      req    = 3'b010;
      step();
      check("t5_gnt", grantId, 1);
      check("t5_busy", busy, 1);
      req       = 3'b000;
      cnt_own   = 0;
      cnt_other = 0;
      for (int s = 0; s < 10; s++) begin
         step();
         if (ack == 3'b010) cnt_own++;
         else if (ack != '0) cnt_other++;
      end
      check("t5_ack_once", cnt_own, 1);
      check("t5_ack_other", cnt_other, 0);
      check("t5_rdata", rdata, regs[9]);
      check("t5_idle", busy, 0);
      // Address bits above the register width must be ignored.
      set_addr(0, 6'h23);
      do_txn(3'b001, 3'b000, a, lat);
      check("t5_next_ack", a, 3'b001);
      check("t5_hi_regaddr", regAddr, 3);
      check("t5_hi_rdata", rdata, regs[3]);

      // ---- test 6: random mixed traffic against the reference model ----
      pulse_reset();
      model_last = NREQ - 1;
      model_reg  = '0;
      model_mem  = '0;
      cur_gnt    = 0;
      prev_busy  = 1'b0;
      for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
      for (int c = 0; c < 10000; c++) begin
         step();
         // A new grant shows up as busy rising. req still holds the value that was sampled.
         if (busy && !prev_busy) begin
            pred = -1;
            for (int k = 1; k <= NREQ; k++) begin
               if (pred < 0 && req[(model_last + k) % NREQ]) pred = (model_last + k) % NREQ;
            end
            check("rnd_gnt", grantId, pred);
            if (pred >= 0) begin
               ga = reqAddr[pred*ADDR_W +: ADDR_W];
               if (reqMem[pred]) begin
                  check("rnd_memaddr", memAddrB, ga);
                  check("rnd_regaddr_hold", regAddr, model_reg);
                  model_mem = ga;
                  exp_q.push_back(mem[ga]);
               end else begin
                  check("rnd_regaddr", regAddr, ga[REG_AW-1:0]);
                  check("rnd_memaddr_hold", memAddrB, model_mem);
                  model_reg = ga[REG_AW-1:0];
                  exp_q.push_back(regs[ga[REG_AW-1:0]]);
               end
               check("rnd_starve", (wait_cnt[pred] <= NREQ) ? 1 : 0, 1);
               for (int i = 0; i < NREQ; i++) begin
                  if (i == pred) wait_cnt[i] = 0;
                  else if (req[i]) wait_cnt[i]++;
               end
               model_last = pred;
               cur_gnt    = pred;
            end
         end
         if (ack != '0) begin
            check("rnd_ack", ack, NREQ'(1) << cur_gnt);
            if (exp_q.size() == 0) check("rnd_q_empty", exp_q.size(), 1);
            else check("rnd_rdata", rdata, exp_q.pop_front());
            // The granted requester either re-requests at once or goes quiet.
            if ($urandom_range(0, 1) == 1) begin
               reqMem[cur_gnt] = 1'($urandom_range(0, 1));
               set_addr(cur_gnt, ADDR_W'($urandom_range(0, 63)));
            end else begin
               req[cur_gnt] = 1'b0;
            end
         end
         prev_busy = busy;
         // Requesters that are idle raise a new request at random.
         for (int i = 0; i < NREQ; i++) begin
            if (!req[i] && $urandom_range(0, 3) == 0) begin
               reqMem[i] = 1'($urandom_range(0, 1));
               set_addr(i, ADDR_W'($urandom_range(0, 63)));
               req[i] = 1'b1;
            end
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
